// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M sequencer: registered multiply plus iterative restoring divide, with stall/flush.
// Optional macro MULDIV_EARLY_OUT_EN lets a division finish early when |divisor| > |dividend|.
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [4:0]       alu_opcode,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             flush,
   output logic             busy,
   output logic             stall,
   output logic             result_valid,
   output logic [WIDTH-1:0] result,
   output logic [2:0]       dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_MUL     = 3'd1,
      S_DIV_RUN = 3'd2,
      S_DIV_FIX = 3'd3,
      S_DONE    = 3'd4
   } state_e;

   state_e           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH:0]   mb_q, mb_d;
   logic [5:0]       cnt_q, cnt_d;
   logic             negq_q, negq_d, nega_q, nega_d, dz_q, dz_d;
   logic [WIDTH-1:0] result_q, result_d;

   logic             is_mul_op, is_div_op, accept;
   logic             in_neg_a, in_neg_b;
   logic [WIDTH-1:0] in_mag_a;
   logic [WIDTH:0]   in_mag_b;
   logic             mul_sa, mul_sb;
   logic [2*WIDTH-1:0] mul_ea, mul_eb, mul_prod;
   logic [WIDTH-1:0] mul_res;
   logic [WIDTH:0]   div_shift;
   logic             div_ge, early_out;
   logic [WIDTH-1:0] quo_fix, rem_fix;

   assign is_mul_op = (alu_opcode[4:2] == 3'b001);
   assign is_div_op = (alu_opcode[4:2] == 3'b010);
   assign accept    = (state_q == S_IDLE) & start & (is_mul_op | is_div_op) & ~flush;

   // DIV and REM (opcode bit 0 clear) are the signed divides.
   assign in_neg_a = is_div_op & ~alu_opcode[0] & operand_a[WIDTH-1];
   assign in_neg_b = is_div_op & ~alu_opcode[0] & operand_b[WIDTH-1];
   assign in_mag_a = in_neg_a ? -operand_a : operand_a;
   assign in_mag_b = {1'b0, (in_neg_b ? -operand_b : operand_b)};

   // Low 2*WIDTH bits of the extended product are exact for every variant.
   assign mul_sa   = op_q[0];
   assign mul_sb   = (op_q == 2'b01);
   assign mul_ea   = {{WIDTH{mul_sa & a_q[WIDTH-1]}}, a_q};
   assign mul_eb   = {{WIDTH{mul_sb & b_q[WIDTH-1]}}, b_q};
   assign mul_prod = mul_ea * mul_eb;
   assign mul_res  = (op_q == 2'b00) ? mul_prod[WIDTH-1:0] : mul_prod[2*WIDTH-1:WIDTH];

   assign div_shift = {rem_q, quo_q[WIDTH-1]};
   assign div_ge    = (div_shift >= mb_q);

`ifdef MULDIV_EARLY_OUT_EN
   assign early_out = (mb_q > {1'b0, quo_q});
`else
   assign early_out = 1'b0;
`endif

   assign quo_fix = dz_q ? '1 : (negq_q ? -quo_q : quo_q);
   assign rem_fix = nega_q ? -rem_q : rem_q;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      quo_d    = quo_q;
      rem_d    = rem_q;
      mb_d     = mb_q;
      cnt_d    = cnt_q;
      negq_d   = negq_q;
      nega_d   = nega_q;
      dz_d     = dz_q;
      result_d = result_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_d    = alu_opcode[1:0];
               a_d     = operand_a;
               b_d     = operand_b;
               quo_d   = in_mag_a;
               rem_d   = '0;
               mb_d    = in_mag_b;
               cnt_d   = '0;
               negq_d  = in_neg_a ^ in_neg_b;
               nega_d  = in_neg_a;
               dz_d    = 1'b0;
               state_d = is_mul_op ? S_MUL : S_DIV_RUN;
            end
         end
         S_MUL: begin
            result_d = mul_res;
            state_d  = S_DONE;
         end
         S_DIV_RUN: begin
            // First cycle: quo_q still holds |a|, so the shortcut remainder is |a|.
            if (cnt_q == 6'd0 && mb_q == '0) begin
               dz_d    = 1'b1;
               rem_d   = quo_q;
               state_d = S_DIV_FIX;
            end else if (cnt_q == 6'd0 && early_out) begin
               rem_d   = quo_q;
               quo_d   = '0;
               state_d = S_DIV_FIX;
            end else begin
               rem_d = div_ge ? WIDTH'(div_shift - mb_q) : div_shift[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], div_ge};
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == 6'(WIDTH-1)) state_d = S_DIV_FIX;
            end
         end
         S_DIV_FIX: begin
            result_d = op_q[1] ? rem_fix : quo_fix;
            state_d  = S_DONE;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (flush && state_q != S_IDLE) begin
         state_d  = S_IDLE;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         quo_q    <= '0;
         rem_q    <= '0;
         mb_q     <= '0;
         cnt_q    <= '0;
         negq_q   <= 1'b0;
         nega_q   <= 1'b0;
         dz_q     <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         quo_q    <= quo_d;
         rem_q    <= rem_d;
         mb_q     <= mb_d;
         cnt_q    <= cnt_d;
         negq_q   <= negq_d;
         nega_q   <= nega_d;
         dz_q     <= dz_d;
         result_q <= result_d;
      end
   end

   assign busy         = (state_q != S_IDLE);
   assign stall        = accept | (busy & (state_q != S_DONE));
   assign result_valid = (state_q == S_DONE) & ~flush;
   assign result       = result_q;
   assign dbg_state    = state_q;

endmodule
